// File: rtl/ray_trace_core.sv
// ray_trace_core: 4-stage pipelined ray/sphere discriminant sign test (optional disc port via RTC_DISC_OUT_EN)
package ray_trace_pkg;
  localparam int CW = 12;
  localparam int RW = 9;
  typedef struct packed {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic signed [CW-1:0] z;
  } Pixel_s;
  typedef struct packed {
    Pixel_s         origin;
    logic [RW-1:0]  radius;
  } sphere_s;
  typedef struct packed {
    sphere_s sphere;
  } World_s;
endpackage

module ray_trace_core
  import ray_trace_pkg::*;
#(
  parameter int DW = 54
) (
  input  logic   clk,
  input  logic   rst_n,
  input  World_s world,
  input  Pixel_s pixel,
  input  logic   in_valid,
  output logic   out_valid,
  output logic   less_than_zero
`ifdef RTC_DISC_OUT_EN
  ,
  output logic signed [DW-1:0] disc
`endif
);
  localparam int PW = 2 * CW;
  localparam int RRW = 2 * RW;
  localparam int AW = PW + 2;
  localparam int KW = PW + 3;
  logic signed [CW-1:0] cx, cy, cz;
  logic signed [PW-1:0] pp_x, pp_y, pp_z, pc_x, pc_y, pc_z, cc_x, cc_y, cc_z;
  logic [RRW-1:0] rr;
  logic [AW-1:0] a_q;
  logic signed [AW-1:0] h_q;
  logic signed [KW-1:0] c_q;
  logic signed [DW-1:0] hh_q, ac_q;
  logic [2:0] vld;
  assign cx = world.sphere.origin.x;
  assign cy = world.sphere.origin.y;
  assign cz = world.sphere.origin.z;
  // Stage 1: every pairwise product the discriminant needs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_x <= '0; pp_y <= '0; pp_z <= '0;
      pc_x <= '0; pc_y <= '0; pc_z <= '0;
      cc_x <= '0; cc_y <= '0; cc_z <= '0;
      rr   <= '0;
    end else begin
      pp_x <= PW'(pixel.x) * PW'(pixel.x);
      pp_y <= PW'(pixel.y) * PW'(pixel.y);
      pp_z <= PW'(pixel.z) * PW'(pixel.z);
      pc_x <= PW'(pixel.x) * PW'(cx);
      pc_y <= PW'(pixel.y) * PW'(cy);
      pc_z <= PW'(pixel.z) * PW'(cz);
      cc_x <= PW'(cx) * PW'(cx);
      cc_y <= PW'(cy) * PW'(cy);
      cc_z <= PW'(cz) * PW'(cz);
      rr   <= RRW'(world.sphere.radius) * RRW'(world.sphere.radius);
    end
  end
  // Stage 2: quadratic coefficients a = d.d, h = d.C, c = C.C - r^2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      h_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= AW'(pp_x) + AW'(pp_y) + AW'(pp_z);
      h_q <= AW'(pc_x) + AW'(pc_y) + AW'(pc_z);
      c_q <= KW'(cc_x) + KW'(cc_y) + KW'(cc_z) - $signed(KW'(rr));
    end
  end
  // Stage 3: the two terms of the half-b discriminant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_q <= '0;
      ac_q <= '0;
    end else begin
      hh_q <= DW'(h_q) * DW'(h_q);
      ac_q <= $signed(DW'(a_q)) * DW'(c_q);
    end
  end
`ifdef RTC_DISC_OUT_EN
  logic signed [DW-1:0] diff;
  assign diff = hh_q - ac_q;
  // Stage 4: register the full discriminant and its sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc           <= '0;
      less_than_zero <= 1'b0;
    end else begin
      disc           <= diff;
      less_than_zero <= diff[DW-1];
    end
  end
`else
  // Stage 4: sign of h^2 - a*c; widths rule out overflow so a signed compare gives the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) less_than_zero <= 1'b0;
    else less_than_zero <= hh_q < ac_q;
  end
`endif
  // Valid tracks the datapath exactly, bubbles included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
    end else begin
      vld       <= {vld[1:0], in_valid};
      out_valid <= vld[2];
    end
  end
endmodule

// File: tb/tb_ray_trace_core.sv
// tb_ray_trace_core: randomized and directed checks of ray_trace_core against a plain-arithmetic model
module tb_ray_trace_core;
  import ray_trace_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  World_s world = '0;
  Pixel_s pixel = '0;
  logic out_valid, less_than_zero;
`ifdef RTC_DISC_OUT_EN
  logic signed [53:0] disc;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {
    bit v;
    bit l;
    longint d;
  } exp_t;
  exp_t q[$];

  ray_trace_core dut (
    .clk(clk),
    .rst_n(rst_n),
    .world(world),
    .pixel(pixel),
    .in_valid(in_valid),
    .out_valid(out_valid),
    .less_than_zero(less_than_zero)
`ifdef RTC_DISC_OUT_EN
    ,
    .disc(disc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic Pixel_s mk_p(int x, int y, int z);
    Pixel_s p;
    p.x = 12'(x);
    p.y = 12'(y);
    p.z = 12'(z);
    return p;
  endfunction

  function automatic World_s mk_w(int x, int y, int z, int r);
    World_s w;
    w.sphere.origin = mk_p(x, y, z);
    w.sphere.radius = 9'(r);
    return w;
  endfunction

  function automatic longint model_disc(Pixel_s p, World_s w);
    longint px = p.x, py = p.y, pz = p.z;
    longint cx = w.sphere.origin.x, cy = w.sphere.origin.y, cz = w.sphere.origin.z;
    longint r = w.sphere.radius;
    longint a = px * px + py * py + pz * pz;
    longint h = px * cx + py * cy + pz * cz;
    longint c = cx * cx + cy * cy + cz * cz - r * r;
    return h * h - a * c;
  endfunction

  function automatic void preload();
    q.delete();
    repeat (4) q.push_back('{0, 0, 0});
  endfunction

  task automatic step(input bit v, input Pixel_s p, input World_s w, output exp_t e,
                      output bit gv, output bit gl, output longint gd);
    longint md;
    @(negedge clk);
    gv = out_valid;
    gl = less_than_zero;
`ifdef RTC_DISC_OUT_EN
    gd = longint'(disc);
`else
    gd = 0;
`endif
    e = q.pop_front();
    in_valid = v;
    pixel = p;
    world = w;
    md = model_disc(p, w);
    q.push_back('{v, md < 0, md});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (less_than_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_ltz got=%b want=0", less_than_zero);
    end
    rst_n = 1'b1;
    preload();
  endtask

  task automatic test_vectors();
    Pixel_s vp[6];
    World_s vw[6];
    bit spec_l[6];
    exp_t e;
    bit gv, gl;
    longint gd;
    vp[0] = mk_p(-320, 240, 15);     vw[0] = mk_w(0, 0, 0, 7);           spec_l[0] = 0;
    vp[1] = mk_p(0, 0, 15);          vw[1] = mk_w(0, 0, 100, 10);        spec_l[1] = 0;
    vp[2] = mk_p(0, 0, 15);          vw[2] = mk_w(100, 0, 100, 10);      spec_l[2] = 1;
    vp[3] = mk_p(0, 0, 1);           vw[3] = mk_w(10, 0, 100, 10);       spec_l[3] = 0;
    vp[4] = mk_p(-2048, -2048, -2048); vw[4] = mk_w(2047, 2047, 2047, 511); spec_l[4] = 0;
    vp[5] = mk_p(0, 0, 0);           vw[5] = mk_w(300, -50, 7, 3);       spec_l[5] = 0;
    for (int k = 0; k < 10; k++) begin
      step(k < 6, k < 6 ? vp[k] : '0, k < 6 ? vw[k] : '0, e, gv, gl, gd);
      total++;
      if (gv !== (k >= 4)) begin
        bad++;
        $display("FAIL vec_valid[%0d] got=%b want=%b", k, gv, k >= 4);
      end
      if (k >= 4) begin
        total++;
        if (gl !== spec_l[k-4]) begin
          bad++;
          $display("FAIL vec_ltz[%0d] got=%b want=%b", k - 4, gl, spec_l[k-4]);
        end
`ifdef RTC_DISC_OUT_EN
        total++;
        if (gd !== e.d) begin
          bad++;
          $display("FAIL vec_disc[%0d] got=%0d want=%0d", k - 4, gd, e.d);
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit gv, gl;
    longint gd;
    for (int k = 0; k < 20; k++) begin
      step(k != 9 && k < 16, k[0] ? mk_p(0, 0, 15) : mk_p(0, 0, 15),
           k[0] ? mk_w(100, 0, 100, 10) : mk_w(0, 0, 100, 10), e, gv, gl, gd);
      if (k >= 4) begin
        total++;
        if (gv !== (k != 13 && k < 20)) begin
          bad++;
          $display("FAIL b2b_valid[%0d] got=%b want=%b", k, gv, k != 13);
        end
        if (k != 13) begin
          total++;
          if (gl !== k[0]) begin
            bad++;
            $display("FAIL b2b_ltz[%0d] got=%b want=%b", k, gl, k[0]);
          end
        end
      end
    end
    repeat (4) begin
      step(0, '0, '0, e, gv, gl, gd);
      total++;
      if (gv !== e.v) begin
        bad++;
        $display("FAIL b2b_drain_valid got=%b want=%b", gv, e.v);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit gv, gl;
    longint gd;
    Pixel_s p;
    World_s w;
    int mode;
    for (int k = 0; k < 304; k++) begin
      mode = $urandom_range(0, 2);
      w.sphere.origin.x = 12'($urandom);
      w.sphere.origin.y = 12'($urandom);
      w.sphere.origin.z = 12'($urandom);
      w.sphere.radius = 9'($urandom);
      p.x = 12'($urandom);
      p.y = 12'($urandom);
      p.z = 12'($urandom);
      if (mode == 1) p = w.sphere.origin;
      if (mode == 2) w.sphere.origin = mk_p($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                                            $urandom_range(0, 200) - 100);
      step(k < 300 && $urandom_range(0, 4) != 0, p, w, e, gv, gl, gd);
      total++;
      if (gv !== e.v) begin
        bad++;
        $display("FAIL rnd_valid[%0d] got=%b want=%b", k, gv, e.v);
      end
      if (e.v) begin
        total++;
        if (gl !== e.l) begin
          bad++;
          $display("FAIL rnd_ltz[%0d] got=%b want=%b disc=%0d", k, gl, e.l, e.d);
        end
`ifdef RTC_DISC_OUT_EN
        total++;
        if (gd !== e.d) begin
          bad++;
          $display("FAIL rnd_disc[%0d] got=%0d want=%0d", k, gd, e.d);
        end
`endif
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit gv, gl;
    longint gd;
    for (int k = 0; k < 6; k++) step(1, mk_p(0, 0, 15), mk_w(100, 0, 100, 10), e, gv, gl, gd);
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || less_than_zero !== 1'b1) begin
      bad++;
      $display("FAIL midrst_before got=%b%b want=11", out_valid, less_than_zero);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_valid_async got=%b want=0", out_valid);
    end
    total++;
    if (less_than_zero !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ltz_async got=%b want=0", less_than_zero);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    preload();
    for (int k = 0; k < 8; k++) begin
      step(0, mk_p(0, 0, 15), mk_w(100, 0, 100, 10), e, gv, gl, gd);
      total++;
      if (gv !== 1'b0) begin
        bad++;
        $display("FAIL midrst_after_valid[%0d] got=%b want=0", k, gv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ray_trace_core.md
Name: ray_trace_core

Overview:
- Fully pipelined ray/sphere hit test for one pixel per clock.
- Camera sits at world origin. The ray direction is the pixel vector d = (px, py, pz). The sphere has centre C and radius r.
- The block computes the half-b discriminant disc = (d·C)² − (d·d)·(C·C − r²) and flags a miss (disc < 0).
- Sits between the pixel scanner and the shading stage.

Parameters:
- CW, 12, signed width of each pixel and sphere-centre coordinate.
- RW, 9, unsigned width of the sphere radius.
- DW, 54, signed width of the internal discriminant.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- world  in  World_s (3·CW+RW = 45 bits)  sphere.origin.x/y/z are signed CW; sphere.radius is unsigned RW.
- pixel  in  Pixel_s (3·CW = 36 bits)  x/y/z, signed CW.
- in_valid  in  1  world/pixel are valid this cycle.
- out_valid  out  1  less_than_zero corresponds to an accepted input.
- less_than_zero  out  1  1 = ray misses the sphere (disc < 0); 0 = hit or tangent.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- While rst_n = 0, all pipeline registers, out_valid and less_than_zero are 0. Deassertion is synchronous to clk by the surrounding reset tree.
- No stall and no backpressure: a new input is accepted every cycle. The datapath advances every cycle regardless of in_valid.
- out_valid is in_valid delayed by exactly 4 cycles. Bubbles propagate.
- Latency is 4 clocks: inputs sampled at edge N produce registered outputs after edge N+4.
- Stage 1 (edge N+1) registers all products, each signed 2·CW = 24 bits:
  - px², py², pz²
  - px·cx, py·cy, pz·cz
  - cx², cy², cz²
  - r², unsigned 2·RW
- Stage 2 (edge N+2) registers the sums:
  - a = Σp², unsigned 26 bits.
  - h = Σ p·c, signed 26 bits.
  - c = Σc² − r², signed 27 bits.
- Stage 3 (edge N+3) registers h² and a·c, both signed DW.
- Stage 4 (edge N+4) computes disc = h² − a·c. It registers less_than_zero = disc[DW−1] and out_valid.
- All arithmetic is exact two's complement with no saturation or truncation. Widths are sized so full-scale inputs (±2048 coordinates, r = 511) cannot overflow.
- disc = 0 (tangent) is a hit: less_than_zero = 0.
- d = (0,0,0) gives a = 0 and disc = 0, so less_than_zero = 0.
- Sphere containing the camera (c < 0) always gives disc > 0, so less_than_zero = 0.
- Reset mid-operation discards all in-flight results. The first out_valid after reset is 4 cycles after the first in_valid sampled with rst_n = 1.

Optional Feature:
RTC_DISC_OUT_EN
- Defined: adds output port disc [DW−1:0], signed. It is registered alongside less_than_zero with the same latency and resets to 0.
- Undefined: the port and its output register do not exist. The sign bit is still computed internally and behaviour is otherwise identical.

Test Plan:
- Sphere C = (0,0,0), r = 7; pixel (−320,240,15); in_valid = 1 → 4 cycles later out_valid = 1, less_than_zero = 0 (disc = 7,851,025).
- C = (0,0,100), r = 10; pixel (0,0,15) → less_than_zero = 0 (disc = 22,500).
- C = (100,0,100), r = 10; pixel (0,0,15) → less_than_zero = 1 (disc = −2,227,500).
- Tangent case: C = (10,0,100), r = 10; pixel (0,0,1) → less_than_zero = 0 (disc = 0). Full-scale case: pixel (−2048,−2048,−2048), C = (2047,2047,2047), r = 511 → less_than_zero = 0, with no overflow against the reference model.
- Throughput: alternate the hit vector (test 2) and the miss vector (test 3) every cycle with in_valid = 1 → from cycle 4 onward, out_valid stays 1 and less_than_zero toggles 0,1,0,1… A single in_valid = 0 cycle yields exactly one out_valid = 0 four cycles later.
- Reset mid-stream: drop rst_n while results are in flight → out_valid and less_than_zero go to 0 immediately, without waiting for a clock edge. After release with in_valid = 0, out_valid stays 0.
